// File: rtl/tmds_channel_scheduler.sv
// One TMDS channel: chooses control / preamble / guard / video symbol each pixel
// clock from a 10-deep lookahead pipe and owns the encoder's running disparity.
module tmds_channel_scheduler #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_data,
    input  logic       de,
    input  logic [1:0] ctl,
    output logic [7:0] enc_pixel_data,
    output logic [4:0] enc_previous_count,
    input  logic [9:0] enc_encoded_data,
    input  logic [4:0] enc_next_count,
    output logic [9:0] tmds_symbol,
    output logic [1:0] period,
    output logic       blank_err
);

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] pixel;
    } sample_t;

    typedef enum logic [1:0] {
        CONTROL  = 2'd0,
        PREAMBLE = 2'd1,
        GUARD    = 2'd2,
        VIDEO    = 2'd3
    } period_t;

    localparam logic [9:0] CTL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] GUARD_SYM  = (CHANNEL == 32'd1) ? 10'b0100110011 : 10'b1011001100;
    localparam logic [1:0] PRE_CTL    = (CHANNEL == 32'd1) ? 2'b01 : 2'b00;

    function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
        case (c)
            2'b00:   ctl_symbol = 10'b1101010100;
            2'b01:   ctl_symbol = 10'b0010101011;
            2'b10:   ctl_symbol = 10'b0101010100;
            2'b11:   ctl_symbol = 10'b1010101011;
            default: ctl_symbol = 10'b1101010100;
        endcase
    endfunction

    sample_t    pipe_r [10];
    period_t    hist_r [10];   // hist_r[0] is the period currently on the output
    logic [4:0] cnt_r;
    logic [9:0] symbol_r;
    logic       err_r;

    period_t    class_s;
    logic [9:0] symbol_s;
    logic [1:0] pre_ctl_s;
    logic       guard_s;
    logic       preamble_s;
    logic       framed_s;
    logic       err_set_s;

    // Classify pipe[9]: pipe[8..7] are lookahead 1..2, pipe[6..0] and live inputs 3..10
    always_comb begin
        guard_s    = pipe_r[8].de | pipe_r[7].de;
        preamble_s = de;
        for (int i = 0; i < 7; i++) begin
            preamble_s = preamble_s | pipe_r[i].de;
        end
        class_s = CONTROL;
        if (pipe_r[9].de) begin
            class_s = VIDEO;
        end else if (guard_s) begin
            class_s = GUARD;
        end else if (preamble_s) begin
            class_s = PREAMBLE;
        end else begin
            class_s = CONTROL;
        end
    end

    // Symbol selection for the classified sample
    always_comb begin
        pre_ctl_s = (CHANNEL == 32'd0) ? pipe_r[9].ctl : PRE_CTL;
        symbol_s  = CTL_SYM_00;
        case (class_s)
            VIDEO:    symbol_s = enc_encoded_data;
            GUARD:    symbol_s = GUARD_SYM;
            PREAMBLE: symbol_s = ctl_symbol(pre_ctl_s);
            CONTROL:  symbol_s = ctl_symbol(pipe_r[9].ctl);
            default:  symbol_s = CTL_SYM_00;
        endcase
    end

    // A video start is well framed only after exactly 8 preamble then 2 guard periods
    always_comb begin
        framed_s = (hist_r[0] == GUARD) && (hist_r[1] == GUARD);
        for (int i = 2; i < 10; i++) begin
            framed_s = framed_s && (hist_r[i] == PREAMBLE);
        end
        err_set_s = (class_s == VIDEO) && (hist_r[0] != VIDEO) && !framed_s;
    end

    // Delay line, period history, disparity and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                pipe_r[i] <= '0;
                hist_r[i] <= CONTROL;
            end
            cnt_r    <= 5'd0;
            symbol_r <= CTL_SYM_00;
            err_r    <= 1'b0;
        end else begin
            pipe_r[0] <= {de, ctl, pixel_data};
            hist_r[0] <= class_s;
            for (int i = 1; i < 10; i++) begin
                pipe_r[i] <= pipe_r[i-1];
                hist_r[i] <= hist_r[i-1];
            end
            cnt_r    <= (class_s == VIDEO) ? enc_next_count : 5'd0;
            symbol_r <= symbol_s;
            err_r    <= err_r | err_set_s;
        end
    end

    assign enc_pixel_data     = pipe_r[9].pixel;
    assign enc_previous_count = cnt_r;
    assign tmds_symbol        = symbol_r;
    assign period             = hist_r[0];
    assign blank_err          = err_r;

endmodule

// File: tb/tb_tmds_channel_scheduler.sv
// Scoreboard bench for all three channel instances with a stand-in encoder and
// a lookahead reference model computed directly from the sample history.
module tb_tmds_channel_scheduler;

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] pixel;
    } smp_t;

    typedef struct packed {
        logic [2:0][9:0] sym;
        logic [2:0][1:0] per;
        logic [2:0]      err;
        logic [2:0][4:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] pixel_data;
    logic       de;
    logic [1:0] ctl;

    logic [7:0] epd    [3];
    logic [4:0] epc    [3];
    logic [9:0] eed    [3];
    logic [4:0] enc_nc [3];
    logic [9:0] sym    [3];
    logic [1:0] per    [3];
    logic       err    [3];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   pushes = 0;
    int   pops   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    smp_t       mh   [11];
    logic [1:0] ph   [3][10];
    logic [4:0] mcnt [3];
    logic       merr [3];

    function automatic logic [9:0] enc_sym(input logic [7:0] p, input logic [4:0] c);
        return {c[1:0] ^ 2'b10, p ^ {c, c[2:0]}};
    endfunction

    function automatic logic [4:0] enc_nxt(input logic [7:0] p, input logic [4:0] c);
        return c + 5'($countones(p)) - 5'd4;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] t [4];
        t[0] = 10'b1101010100;
        t[1] = 10'b0010101011;
        t[2] = 10'b0101010100;
        t[3] = 10'b1010101011;
        return t[c];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_ch
        tmds_channel_scheduler #(.CHANNEL(g)) dut (
            .clk                (clk),
            .rst                (rst),
            .pixel_data         (pixel_data),
            .de                 (de),
            .ctl                (ctl),
            .enc_pixel_data     (epd[g]),
            .enc_previous_count (epc[g]),
            .enc_encoded_data   (eed[g]),
            .enc_next_count     (enc_nc[g]),
            .tmds_symbol        (sym[g]),
            .period             (per[g]),
            .blank_err          (err[g])
        );
        assign eed[g]    = enc_sym(epd[g], epc[g]);
        assign enc_nc[g] = enc_nxt(epd[g], epc[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s ch%0d cycle %0d: got %h expected %h", nm, ch, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 11; i++) mh[i] = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 10; i++) ph[c][i] = 2'd0;
            mcnt[c] = 5'd0;
            merr[c] = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        for (int c = 0; c < 3; c++) begin
            chk("rst_symbol", c, 32'(sym[c]), 32'(10'b1101010100));
            chk("rst_period", c, 32'(per[c]), 32'd0);
            chk("rst_blank_err", c, 32'(err[c]), 32'd0);
            chk("rst_cnt", c, 32'(epc[c]), 32'd0);
            chk("rst_enc_pixel", c, 32'(epd[c]), 32'd0);
        end
    endtask

    // Drive one sample, predict the output registered at the coming edge, advance a cycle
    task automatic step(input logic d, input logic [1:0] c, input logic [7:0] p);
        exp_t       e;
        int         k;
        logic [1:0] cls;
        logic       framed;
        de         = d;
        ctl        = c;
        pixel_data = p;
        for (int i = 0; i < 10; i++) mh[i] = mh[i+1];
        mh[10] = {d, c, p};
        k = 0;
        for (int i = 10; i >= 1; i--) if (mh[i].de) k = i;
        if (mh[0].de)   cls = 2'd3;
        else if (k == 0) cls = 2'd0;
        else if (k <= 2) cls = 2'd2;
        else             cls = 2'd1;
        for (int ch = 0; ch < 3; ch++) begin
            case (cls)
                2'd3: begin
                    e.sym[ch] = enc_sym(mh[0].pixel, mcnt[ch]);
                    mcnt[ch]  = enc_nxt(mh[0].pixel, mcnt[ch]);
                end
                2'd2: e.sym[ch] = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
                2'd1: e.sym[ch] = ctl_sym((ch == 0) ? mh[0].ctl : ((ch == 1) ? 2'b01 : 2'b00));
                default: e.sym[ch] = ctl_sym(mh[0].ctl);
            endcase
            if (cls != 2'd3) mcnt[ch] = 5'd0;
            if (cls == 2'd3 && ph[ch][9] != 2'd3) begin
                framed = (ph[ch][9] == 2'd2) && (ph[ch][8] == 2'd2);
                for (int i = 0; i < 8; i++) framed = framed && (ph[ch][i] == 2'd1);
                if (!framed) merr[ch] = 1'b1;
            end
            for (int i = 0; i < 9; i++) ph[ch][i] = ph[ch][i+1];
            ph[ch][9] = cls;
            e.per[ch] = cls;
            e.err[ch] = merr[ch];
            e.cnt[ch] = mcnt[ch];
        end
        exp_q.push_back(e);
        pushes++;
        @(posedge clk);
        #2;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom), 8'($urandom));
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        de         = 1'b0;
        ctl        = 2'b00;
        pixel_data = 8'h00;
        #1;
        check_reset_values();
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: every edge outside reset presents one symbol per channel
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                pops++;
                for (int c = 0; c < 3; c++) begin
                    chk("tmds_symbol", c, 32'(sym[c]), 32'(mon_e.sym[c]));
                    chk("period", c, 32'(per[c]), 32'(mon_e.per[c]));
                    chk("blank_err", c, 32'(err[c]), 32'(mon_e.err[c]));
                    chk("enc_previous_count", c, 32'(epc[c]), 32'(mon_e.cnt[c]));
                end
            end
        end
    end

    initial begin
        int gaps [8];
        gaps = '{12, 5, 1, 10, 9, 3, 15, 2};
        rst        = 1'b1;
        de         = 1'b0;
        ctl        = 2'b00;
        pixel_data = 8'h00;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            check_reset_values();
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Long blanking with hsync toggling, then a short line of zero pixels
        for (int i = 0; i < 20; i++) step(1'b0, 2'(i & 1), 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 8'h00);

        // Lines separated by assorted blanking lengths, including a 1-cycle pulse
        for (int i = 0; i < 8; i++) begin
            blank(gaps[i]);
            if (i == 0) line(1);
            else line(int'($urandom_range(1, 6)));
        end
        blank(12);

        // Reset in the middle of a video run, then a properly framed line
        blank(15);
        line(14);
        do_reset();
        blank(20);
        line(5);
        blank(12);

        // Video arriving too soon after reset
        do_reset();
        blank(3);
        line(4);
        blank(12);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 0, 32'(pops), 32'(pushes));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_channel_scheduler.md
# tmds_channel_scheduler

Sequences one TMDS channel of the HDMI transmitter: per pixel clock, decides whether the channel emits a control symbol, the video preamble, the video guard band or a TMDS-encoded pixel. It owns the running-disparity register that the combinational 8b/10b video encoder consumes and updates. It drives that encoder through an exposed port pair, and one instance per channel (0, 1, 2) sits between the video timing source and the serializer.

## Interface
- CHANNEL, 0: TMDS channel index, legal values 0/1/2; selects guard-band and preamble CTL values.
- clk  in  1  pixel clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pixel_data  in  8  pixel byte for this channel.
- de  in  1  data enable; 1 = active video sample.
- ctl  in  2  control bits {c1,c0}; for CHANNEL 0 these are {vsync,hsync}.
- enc_pixel_data  out  8  byte presented to the encoder (combinational from pipeline).
- enc_previous_count  out  5  signed disparity presented to the encoder (equals cnt).
- enc_encoded_data  in  10  encoder result.
- enc_next_count  in  5  signed encoder disparity result.
- tmds_symbol  out  10  registered 10-bit symbol to serializer.
- period  out  2  registered class of tmds_symbol: 0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 VIDEO.
- blank_err  out  1  sticky: a video period started with truncated preamble/guard.

## Operation
- Input delay line pipe[0..9] of {de, ctl, pixel_data}; pipe[0] loads inputs each edge, pipe[i] <= pipe[i-1]. Current sample = pipe[9].
- Lookahead: distance d = 1..9 refers to pipe[9-d]; d = 10 refers to live inputs. Let d_min = smallest d with de = 1; none if no such d.
- Output class of current sample:
  - pipe[9].de = 1 -> VIDEO.
  - otherwise d_min in 1..2 -> GUARD.
  - otherwise d_min in 3..10 -> PREAMBLE.
  - otherwise -> CONTROL.
- Symbols (bit 9 first):
  - CONTROL: ctl 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - PREAMBLE: control symbol of pipe[9].ctl for CHANNEL 0; ctl forced 01 for CHANNEL 1 (0010101011); forced 00 for CHANNEL 2 (1101010100).
  - GUARD: 1011001100 for CHANNEL 0 and 2; 0100110011 for CHANNEL 1.
  - VIDEO: enc_encoded_data.
- Disparity register cnt (5-bit signed):
  - VIDEO cycle: cnt <= enc_next_count.
  - Any other class: cnt <= 0.
  - No saturation; value taken verbatim from encoder.
- enc_pixel_data = pipe[9].pixel_data; enc_previous_count = cnt; both are combinational.
- blank_err: set when a VIDEO cycle is registered and the previous 10 registered periods were not exactly 8 PREAMBLE followed by 2 GUARD, unless the previous period was VIDEO. Cleared only by rst.
- Short blanking (<10 de-low cycles between active lines) truncates the PREAMBLE first, then the GUARD. VIDEO is never delayed or dropped.

## Timing
- Latency: the sample presented before edge n appears on tmds_symbol/period after edge n+10.
- Back-to-back video is continuous; no bubbles; one symbol per clock.
- A de=1 pulse of length 1 yields exactly 1 VIDEO cycle; cnt returns to 0 on the next non-video cycle.
- Reset (any time, asynchronous):
  - All pipe entries cleared (de=0, ctl=00, pixel=0) and cnt=0.
  - tmds_symbol=1101010100, period=CONTROL, blank_err=0.
  - Lookahead history is discarded.
- After reset deassertion, de=1 within the first 10 cycles produces truncated preamble/guard and sets blank_err.
- Simultaneous end and start: de falling then rising 1 cycle later gives 1 GUARD cycle between videos and sets blank_err.

## Test plan
- Reset with ctl=00, de=0 -> tmds_symbol=1101010100, period=0, blank_err=0, held indefinitely.
- CHANNEL 1: de low 20 cycles, then high 4 cycles with pixel 0x00 -> output is CONTROL, then 8 PREAMBLE symbols 0010101011, then 2 GUARD symbols 0100110011, then 4 VIDEO cycles; blank_err stays 0.
- Video run of 0x00 (model encoder) -> cnt seen on enc_previous_count follows 0, then successive enc_next_count values; cnt reads 0 at the first non-video cycle.
- CHANNEL 0, hsync toggling during blanking -> control symbols track ctl with 10-cycle latency; preamble carries the live ctl code, and guard is 1011001100.
- Blanking of only 5 cycles between lines -> 3 PREAMBLE, 2 GUARD, VIDEO starts on time; blank_err=1 and remains set until rst.
- Assert rst mid-video -> outputs return to their reset values immediately, cnt=0; the following line gets a full preamble if blanking ≥10.
